// File: rtl/yellow_car_pkg.sv
// Shared types and default constants for the yellow car movers.
// Imported by yellow_car_lane and yellow_car_mover.
package yellow_car_pkg;

    typedef logic [9:0] ypos_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        HOLD = 2'd2
    } lane_state_t;

    localparam logic [7:0] DEF_KEY_S      = 8'h16;
    localparam ypos_t      DEF_Y_MIN      = 10'd0;
    localparam ypos_t      DEF_Y_MAX      = 10'd480;
    localparam ypos_t      DEF_CAR_SIZE_Y = 10'd99;
    localparam ypos_t      DEF_STEP       = 10'd4;

endpackage

// File: rtl/yellow_car_lane.sv
// One lane: IDLE/MOVE/HOLD FSM plus the car's top-Y register.
// Ports: Clk, Reset, tick, freeze, key[7:0] in; pos[9:0], busy out.
module yellow_car_lane
    import yellow_car_pkg::*;
#(
    parameter logic [7:0] KEY_S = DEF_KEY_S,
    parameter ypos_t      Y_MIN = DEF_Y_MIN,
    parameter ypos_t      Y_MAX = DEF_Y_MAX,
    parameter ypos_t      STEP  = DEF_STEP
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       freeze,
    input  logic [7:0] key,
    output logic [9:0] pos,
    output logic       busy
);

    lane_state_t state;
    lane_state_t state_nxt;
    logic [9:0]  pos_nxt;
    logic [10:0] sum;
    logic        key_hit;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            pos   <= Y_MIN;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
        end
    end

    // 11-bit sum so the off-screen compare never wraps
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        key_hit   = (key == KEY_S);
        sum       = {1'b0, pos} + {1'b0, STEP};
        unique case (state)
            IDLE: begin
                pos_nxt = Y_MIN;
                if (key_hit)
                    state_nxt = MOVE;
            end
            MOVE: begin
                if (tick && !freeze) begin
                    if (sum >= {1'b0, Y_MAX}) begin
                        pos_nxt   = Y_MIN;
                        state_nxt = HOLD;
                    end else begin
                        pos_nxt = sum[9:0];
                    end
                end
            end
            HOLD: begin
                // wait for key release so a held key cannot relaunch
                pos_nxt = Y_MIN;
                if (!key_hit)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                pos_nxt   = Y_MIN;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: rtl/yellow_car_mover.sv
// Frame-tick generation and three yellow car lanes.
// Ports: Clk, Reset, frame_clk, freeze, keycode_s1..3 in; car pos/pos_max, Y_Min, lane_busy out.
module yellow_car_mover
    import yellow_car_pkg::*;
#(
    parameter logic [7:0] KEY_S      = DEF_KEY_S,
    parameter ypos_t      Y_MIN      = DEF_Y_MIN,
    parameter ypos_t      Y_MAX      = DEF_Y_MAX,
    parameter ypos_t      CAR_SIZE_Y = DEF_CAR_SIZE_Y,
    parameter ypos_t      STEP       = DEF_STEP
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       freeze,
    input  logic [7:0] keycode_s1,
    input  logic [7:0] keycode_s2,
    input  logic [7:0] keycode_s3,
    output logic [9:0] car1_pos,
    output logic [9:0] car2_pos,
    output logic [9:0] car3_pos,
    output logic [9:0] car1_pos_max,
    output logic [9:0] car2_pos_max,
    output logic [9:0] car3_pos_max,
    output logic [9:0] yellowcar1_Y_Min,
    output logic [9:0] yellowcar2_Y_Min,
    output logic [9:0] yellowcar3_Y_Min,
    output logic [2:0] lane_busy
);

    logic fc_s1;
    logic fc_s2;
    logic fc_s3;
    logic tick;

    // two sync flops, one history flop, registered rise -> 3rd edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_s1 <= 1'b0;
            fc_s2 <= 1'b0;
            fc_s3 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            fc_s1 <= frame_clk;
            fc_s2 <= fc_s1;
            fc_s3 <= fc_s2;
            tick  <= fc_s2 & ~fc_s3;
        end
    end

    yellow_car_lane #(
        .KEY_S(KEY_S), .Y_MIN(Y_MIN),
        .Y_MAX(Y_MAX), .STEP(STEP)
    ) u_lane1 (
        .Clk(Clk), .Reset(Reset),
        .tick(tick), .freeze(freeze),
        .key(keycode_s1),
        .pos(car1_pos), .busy(lane_busy[0])
    );

    yellow_car_lane #(
        .KEY_S(KEY_S), .Y_MIN(Y_MIN),
        .Y_MAX(Y_MAX), .STEP(STEP)
    ) u_lane2 (
        .Clk(Clk), .Reset(Reset),
        .tick(tick), .freeze(freeze),
        .key(keycode_s2),
        .pos(car2_pos), .busy(lane_busy[1])
    );

    yellow_car_lane #(
        .KEY_S(KEY_S), .Y_MIN(Y_MIN),
        .Y_MAX(Y_MAX), .STEP(STEP)
    ) u_lane3 (
        .Clk(Clk), .Reset(Reset),
        .tick(tick), .freeze(freeze),
        .key(keycode_s3),
        .pos(car3_pos), .busy(lane_busy[2])
    );

    always_comb begin
        car1_pos_max     = car1_pos + CAR_SIZE_Y;
        car2_pos_max     = car2_pos + CAR_SIZE_Y;
        car3_pos_max     = car3_pos + CAR_SIZE_Y;
        yellowcar1_Y_Min = Y_MIN;
        yellowcar2_Y_Min = Y_MIN;
        yellowcar3_Y_Min = Y_MIN;
    end

endmodule

// File: tb/tb_yellow_car_mover.sv
// Scoreboard bench for yellow_car_mover: frame stimulus pushes
// expected car state; a monitor compares after every frame tick.
module tb_yellow_car_mover;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       freeze;
    logic [7:0] keycode_s1, keycode_s2, keycode_s3;
    logic [9:0] car1_pos, car2_pos, car3_pos;
    logic [9:0] car1_pos_max, car2_pos_max, car3_pos_max;
    logic [9:0] y1_min, y2_min, y3_min;
    logic [2:0] lane_busy;

    typedef struct {
        logic [9:0] p1;
        logic [9:0] p2;
        logic [9:0] p3;
        logic [2:0] b;
        int         id;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int seq = 0;

    always #10 Clk = ~Clk;

    yellow_car_mover dut (
        .Clk(Clk), .Reset(Reset),
        .frame_clk(frame_clk), .freeze(freeze),
        .keycode_s1(keycode_s1),
        .keycode_s2(keycode_s2),
        .keycode_s3(keycode_s3),
        .car1_pos(car1_pos), .car2_pos(car2_pos),
        .car3_pos(car3_pos),
        .car1_pos_max(car1_pos_max),
        .car2_pos_max(car2_pos_max),
        .car3_pos_max(car3_pos_max),
        .yellowcar1_Y_Min(y1_min),
        .yellowcar2_Y_Min(y2_min),
        .yellowcar3_Y_Min(y3_min),
        .lane_busy(lane_busy)
    );

    task automatic push(input logic [9:0] p1, input logic [9:0] p2,
                        input logic [9:0] p3, input logic [2:0] b);
        exp_t e;
        e.p1 = p1; e.p2 = p2; e.p3 = p3; e.b = b; e.id = seq;
        seq++;
        q.push_back(e);
    endtask

    task automatic frame();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    task automatic chk(input string name, input logic [9:0] p1,
                       input logic [9:0] p2, input logic [9:0] p3,
                       input logic [2:0] b);
        checks++;
        if (car1_pos !== p1 || car2_pos !== p2 ||
            car3_pos !== p3 || lane_busy !== b) begin
            errors++;
            $display("FAIL %s got %0d %0d %0d busy %b want %0d %0d %0d busy %b",
                     name, car1_pos, car2_pos, car3_pos, lane_busy,
                     p1, p2, p3, b);
        end
    endtask

    // Monitor: the DUT presents a new position on the edge after its tick
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (dut.tick === 1'b1) begin
                @(negedge Clk);
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick got %0d %0d %0d want none",
                             car1_pos, car2_pos, car3_pos);
                end else begin
                    e = q.pop_front();
                    if (car1_pos !== e.p1 || car2_pos !== e.p2 ||
                        car3_pos !== e.p3 || lane_busy !== e.b ||
                        car1_pos_max !== e.p1 + 10'd99 ||
                        car2_pos_max !== e.p2 + 10'd99 ||
                        car3_pos_max !== e.p3 + 10'd99) begin
                        errors++;
                        $display("FAIL frame%0d got %0d %0d %0d max %0d %0d %0d busy %b want %0d %0d %0d busy %b",
                                 e.id, car1_pos, car2_pos, car3_pos,
                                 car1_pos_max, car2_pos_max, car3_pos_max,
                                 lane_busy, e.p1, e.p2, e.p3, e.b);
                    end
                end
            end
        end
    end

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        freeze = 1'b0;
        keycode_s1 = 8'h00;
        keycode_s2 = 8'h00;
        keycode_s3 = 8'h00;
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("reset", 10'd0, 10'd0, 10'd0, 3'b000);
        checks++;
        if (car1_pos_max !== 10'd99 || car3_pos_max !== 10'd99 ||
            y1_min !== 10'd0 || y2_min !== 10'd0 || y3_min !== 10'd0) begin
            errors++;
            $display("FAIL reset_max got %0d %0d min %0d want 99 99 min 0",
                     car1_pos_max, car3_pos_max, y2_min);
        end

        // idle frames, non-KEY_S code is ignored
        keycode_s2 = 8'h15;
        for (int k = 0; k < 10; k++) begin
            push(0, 0, 0, 3'b000);
            frame();
        end
        keycode_s2 = 8'h00;

        // lane 1 full descent with key held
        keycode_s1 = 8'h16;
        @(negedge Clk);
        chk("launch1_busy", 10'd0, 10'd0, 10'd0, 3'b001);
        for (int k = 1; k <= 119; k++) begin
            push(10'(4 * k), 0, 0, 3'b001);
            frame();
        end
        push(0, 0, 0, 3'b001);
        frame();
        keycode_s1 = 8'h00;
        @(negedge Clk);
        chk("hold_to_idle1", 10'd0, 10'd0, 10'd0, 3'b000);

        // lanes 1 and 3 together, key held through wrap + 3 ticks
        keycode_s1 = 8'h16;
        keycode_s3 = 8'h16;
        for (int k = 1; k <= 119; k++) begin
            push(10'(4 * k), 0, 10'(4 * k), 3'b101);
            frame();
        end
        for (int k = 0; k < 4; k++) begin
            push(0, 0, 0, 3'b101);
            frame();
        end
        keycode_s1 = 8'h00;
        keycode_s3 = 8'h00;
        @(negedge Clk);
        chk("hold_release13", 10'd0, 10'd0, 10'd0, 3'b000);

        // relaunch, then drop key mid-descent: car still completes
        keycode_s1 = 8'h16;
        push(4, 0, 0, 3'b001);
        frame();
        keycode_s1 = 8'h00;
        for (int k = 2; k <= 119; k++) begin
            push(10'(4 * k), 0, 0, 3'b001);
            frame();
        end
        push(0, 0, 0, 3'b001);
        frame();
        chk("complete_idle1", 10'd0, 10'd0, 10'd0, 3'b000);

        // lanes 2 and 3 to 200, then freeze
        keycode_s2 = 8'h16;
        keycode_s3 = 8'h16;
        for (int k = 1; k <= 50; k++) begin
            push(0, 10'(4 * k), 10'(4 * k), 3'b110);
            frame();
        end
        keycode_s2 = 8'h00;
        keycode_s3 = 8'h00;
        freeze = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push(0, 200, 200, 3'b110);
            frame();
        end
        freeze = 1'b0;
        push(0, 204, 204, 3'b110);
        frame();

        // long frame_clk high: exactly one step
        push(0, 208, 208, 3'b110);
        @(negedge Clk) frame_clk = 1'b1;
        repeat (1000) @(negedge Clk);
        chk("long_high", 10'd0, 10'd208, 10'd208, 3'b110);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);

        // advance to 300, then reset mid-descent
        for (int k = 53; k <= 75; k++) begin
            push(0, 10'(4 * k), 10'(4 * k), 3'b110);
            frame();
        end
        chk("at300", 10'd0, 10'd300, 10'd300, 3'b110);
        Reset = 1'b1;
        @(negedge Clk);
        chk("reset_mid", 10'd0, 10'd0, 10'd0, 3'b000);
        Reset = 1'b0;
        repeat (20) @(negedge Clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_ticks got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
